lfsr_period_monitor: RTL and testbench

Hardware period checker that sits directly downstream of the 8-bit Fibonacci LFSR (taps 8,6,3,2). On command it captures the first LFSR state seen under `ENA` and counts enabled steps until that state recurs. It reports the measured period, or flags a zero-state lockup, or flags a timeout when the state never recurs. It replaces bench-side cycle detection, so the LFSR can be self-checked on the board.

---
 rtl/lfsr_period_monitor.sv | 111 +++++++++++
 tb/tb_lfsr_period_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of an LFSR state stream sampled under ENA.
// Reports the period, a zero-state lockup, or a timeout if the first state never recurs.
module lfsr_period_monitor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ENA,
  input  logic [WIDTH:1]   LFSR_in,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH:0]   PERIOD,
  output logic             LOCKUP,
  output logic             TIMEOUT
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StReport} state_e;

  localparam logic [WIDTH:0] CntMax = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CntOne = {{WIDTH{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH:1]   first_q, first_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    lockup_d  = lockup_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d   = StArm;
          period_d  = '0;
          lockup_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StArm: begin
        if (ENA) begin
          if (LFSR_in == '0) begin
            lockup_d = 1'b1;
            period_d = '0;
            state_d  = StReport;
          end else begin
            first_d = LFSR_in;
            cnt_d   = CntOne;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (ENA) begin
          if (LFSR_in == first_q) begin
            period_d = cnt_q;
            state_d  = StReport;
          end else if (cnt_q == CntMax) begin
            timeout_d = 1'b1;
            period_d  = '0;
            state_d   = StReport;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    // Flags are derived from the next state so BUSY/DONE stay purely registered.
    busy_d = (state_d != StIdle);
    done_d = (state_d == StReport);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      first_q   <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      lockup_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      lockup_q  <= lockup_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PERIOD  = period_q;
  assign LOCKUP  = lockup_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed scoreboard bench for lfsr_period_monitor: expected results are queued at START
// and compared when DONE rises, together with the enabled-sample count that produced them.
module tb_lfsr_period_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       ENA;
  logic [8:1] LFSR_in;
  logic       BUSY;
  logic       DONE;
  logic [8:0] PERIOD;
  logic       LOCKUP;
  logic       TIMEOUT;

  lfsr_period_monitor #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .ENA     (ENA),
    .LFSR_in (LFSR_in),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .PERIOD  (PERIOD),
    .LOCKUP  (LOCKUP),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned period;
    bit          lock;
    bit          tout;
    int unsigned samples;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  localparam int ModeLfsr = 0;
  localparam int ModeZero = 1;
  localparam int ModeDir  = 2;
  localparam int ModeConst = 3;
  localparam int ModeRho  = 4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:1] lfsr_next(input logic [8:1] s);
    return {s[7:1], s[8] ^ s[6] ^ s[3] ^ s[2]};
  endfunction

  // Non-LFSR streams indexed by enabled-sample number.
  function automatic logic [8:1] stream_val(input int mode, input int idx);
    logic [7:0] dir [4];
    int r;
    dir = '{8'h11, 8'h22, 8'h33, 8'h44};
    case (mode)
      ModeZero:  return 8'h00;
      ModeDir:   return dir[idx % 4];
      ModeConst: return 8'h5A;
      ModeRho: begin
        if (idx == 0) return 8'h80;
        r = (idx - 1) % 254;
        // 0x01..0x7F then 0x81..0xFF: 0x80 never comes back
        return (r < 127) ? 8'(r + 1) : 8'(r + 2);
      end
      default:   return 8'h00;
    endcase
  endfunction

  task automatic measure(input string name, input int mode, input int unsigned exp_p,
                         input bit exp_l, input bit exp_t, input int unsigned exp_n,
                         input bit rand_ena, input bit hold_start);
    logic [8:1] lfsr;
    int unsigned n;
    bit seen;
    bit ena;
    exp_t e;
    lfsr = 8'h01;
    sb.push_back('{exp_p, exp_l, exp_t, exp_n});
    START = 1'b1; ENA = 1'b1; LFSR_in = 8'h00;
    @(posedge CLK); #1;
    if (!hold_start) START = 1'b0;
    check({name, "_busy_on_start"}, 32'(BUSY), 32'd1);
    check({name, "_results_cleared"}, 32'({PERIOD, LOCKUP, TIMEOUT}), 32'd0);
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      ena = rand_ena ? 1'($urandom_range(0, 1)) : 1'b1;
      ENA = ena;
      LFSR_in = (mode == ModeLfsr) ? lfsr : stream_val(mode, int'(n));
      @(posedge CLK); #1;
      if (ena) begin
        n++;
        if (mode == ModeLfsr) lfsr = lfsr_next(lfsr);
      end
      if (DONE) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check({name, "_samples_to_done"}, n, e.samples);
      check({name, "_period"}, 32'(PERIOD), e.period);
      check({name, "_lockup"}, 32'(LOCKUP), 32'(e.lock));
      check({name, "_timeout"}, 32'(TIMEOUT), 32'(e.tout));
      check({name, "_busy_in_report"}, 32'(BUSY), 32'd1);
      ENA = 1'b0;
      @(posedge CLK); #1;
      check({name, "_done_one_cycle"}, 32'(DONE), 32'd0);
      check({name, "_busy_cleared"}, 32'(BUSY), 32'd0);
      START = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check({name, "_result_held"}, 32'({PERIOD, LOCKUP, TIMEOUT}),
            32'({e.period[8:0], e.lock, e.tout}));
      check({name, "_idle_busy"}, 32'(BUSY), 32'd0);
    end
    START = 1'b0;
  endtask

  initial begin
    logic [8:1] lfsr;
    int dones;
    RST = 1'b1; START = 1'b0; ENA = 1'b0; LFSR_in = 8'h00;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("reset_outputs", 32'({BUSY, DONE, PERIOD, LOCKUP, TIMEOUT}), 32'd0);
    check("reset_first", 32'(dut.first_q), 32'd0);
    check("reset_cnt", 32'(dut.cnt_q), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    measure("lfsr_ena1",  ModeLfsr,  255, 1'b0, 1'b0, 256, 1'b0, 1'b0);
    measure("lfsr_rand",  ModeLfsr,  255, 1'b0, 1'b0, 256, 1'b1, 1'b0);
    measure("zero_lock",  ModeZero,  0,   1'b1, 1'b0, 1,   1'b0, 1'b0);
    measure("directed",   ModeDir,   4,   1'b0, 1'b0, 5,   1'b0, 1'b0);
    measure("constant",   ModeConst, 1,   1'b0, 1'b0, 2,   1'b0, 1'b0);
    measure("rho_timeout", ModeRho,  0,   1'b0, 1'b1, 257, 1'b0, 1'b0);
    measure("start_held", ModeDir,   4,   1'b0, 1'b0, 5,   1'b0, 1'b1);

    // Abort a measurement with reset while in RUN.
    lfsr = 8'h01;
    START = 1'b1; ENA = 1'b1; LFSR_in = lfsr;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      LFSR_in = lfsr;
      @(posedge CLK); #1;
      lfsr = lfsr_next(lfsr);
    end
    check("pre_reset_busy", 32'(BUSY), 32'd1);
    RST = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    check("midrun_reset_outputs", 32'({BUSY, DONE, PERIOD, LOCKUP, TIMEOUT}), 32'd0);
    check("midrun_reset_cnt", 32'(dut.cnt_q), 32'd0);
    RST = 1'b0; START = 1'b0;
    dones = 0;
    for (int i = 0; i < 300; i++) begin
      LFSR_in = lfsr;
      @(posedge CLK); #1;
      lfsr = lfsr_next(lfsr);
      if (DONE) dones++;
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    measure("after_reset", ModeLfsr, 255, 1'b0, 1'b0, 256, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
